// File: rtl/traffic_phase_controller.sv
// ---------------------------------------------------------------------------
// traffic_phase_controller
//
// Cycles a set of mutually conflicting vehicle phases through
// GREEN -> YELLOW -> ALL-RED. A pedestrian WALK interval is inserted after
// the all-red clearance whenever a push-button request is pending. Each
// state lasts a fixed number of cycles, counted by a down-timer that is
// loaded with (time-1) on entry.
//
// Optional feature (compile-time macro):
//   PED_EARLY_CUT_EN - a pending pedestrian request cuts the current green
//                      short once it has run at least GREEN_MIN cycles.
//                      Without the macro, green always runs GREEN_TIME
//                      cycles and the green-elapsed counter is not built.
//
// Ports:
//   clk          single clock, all logic on posedge
//   reset        synchronous, active-high reset
//   ped_request  pedestrian push-button (level or one-cycle pulse)
//   light        per-phase light code, phase p at [2p+1:2p]
//                (00 red, 01 green, 10 yellow)
//   ped_light    high during WALK
//   ped_wait     high while a pedestrian request is latched and unserved
//   phase        index of the current or most recent vehicle phase
// All outputs are registered.
// ---------------------------------------------------------------------------
module traffic_phase_controller #(
   parameter int NUM_PHASES  = 2,
   parameter int CNT_W       = 16,
   parameter int GREEN_TIME  = 8,
   parameter int GREEN_MIN   = 3,
   parameter int YELLOW_TIME = 2,
   parameter int ALLRED_TIME = 1,
   parameter int WALK_TIME   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ped_request,
   output logic [2*NUM_PHASES-1:0]       light,
   output logic                          ped_light,
   output logic                          ped_wait,
   output logic [$clog2(NUM_PHASES)-1:0] phase
);

   localparam int PH_W = $clog2(NUM_PHASES);

   localparam logic [1:0] LC_RED    = 2'b00;
   localparam logic [1:0] LC_GREEN  = 2'b01;
   localparam logic [1:0] LC_YELLOW = 2'b10;

   localparam logic [CNT_W-1:0] TIMER_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] TIMER_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TIME - 1);
   localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TIME - 1);
   localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TIME - 1);
   localparam logic [CNT_W-1:0] WALK_LOAD   = CNT_W'(WALK_TIME - 1);

   localparam logic [PH_W-1:0] PH_ZERO = {PH_W{1'b0}};
   localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(NUM_PHASES - 1);

   // Reject illegal configurations at elaboration time.
   if (NUM_PHASES < 2 || NUM_PHASES > 8) begin : g_bad_num_phases
      $error("traffic_phase_controller: NUM_PHASES must be in 2..8");
   end
   if (GREEN_MIN < 1 || GREEN_MIN > GREEN_TIME) begin : g_bad_green_min
      $error("traffic_phase_controller: GREEN_MIN must be in 1..GREEN_TIME");
   end

   typedef enum logic [1:0] {
      ST_GREEN  = 2'b00,
      ST_YELLOW = 2'b01,
      ST_ALLRED = 2'b10,
      ST_WALK   = 2'b11
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [CNT_W-1:0]        timer_r;
   logic [CNT_W-1:0]        timer_nxt_s;
   logic [PH_W-1:0]         phase_r;
   logic [PH_W-1:0]         phase_nxt_s;
   logic                    ped_wait_r;
   logic                    ped_wait_nxt_s;
   logic [2*NUM_PHASES-1:0] light_r;
   logic                    ped_light_r;
   logic                    green_done_s;

`ifdef PED_EARLY_CUT_EN
   localparam logic [CNT_W-1:0] GREEN_MIN_M1 = CNT_W'(GREEN_MIN - 1);

   // Number of green cycles already completed before the current one.
   logic [CNT_W-1:0]        green_elapsed_r;
   logic [CNT_W-1:0]        green_elapsed_nxt_s;
`endif

   // Light vector for a given state and phase: only the active phase is
   // ever non-red, so the 11 code cannot appear.
   function automatic logic [2*NUM_PHASES-1:0] encode_light(
      input state_t          st,
      input logic [PH_W-1:0] ph
   );
      logic [2*NUM_PHASES-1:0] v;
      v = {(2*NUM_PHASES){1'b0}};
      for (int p = 0; p < NUM_PHASES; p++) begin
         if (PH_W'(p) == ph) begin
            case (st)
               ST_GREEN:  v[2*p +: 2] = LC_GREEN;
               ST_YELLOW: v[2*p +: 2] = LC_YELLOW;
               default:   v[2*p +: 2] = LC_RED;
            endcase
         end else begin
            v[2*p +: 2] = LC_RED;
         end
      end
      return v;
   endfunction

   // Successor phase index with wrap from the last phase back to zero.
   function automatic logic [PH_W-1:0] next_phase(input logic [PH_W-1:0] ph);
      logic [PH_W-1:0] n;
      if (ph == PH_LAST) begin
         n = PH_ZERO;
      end else begin
         n = ph + PH_ONE;
      end
      return n;
   endfunction

   // Green end condition: timer expiry, or an early cut for a waiting
   // pedestrian once the minimum green (counting this cycle) is reached.
   always_comb begin
`ifdef PED_EARLY_CUT_EN
      green_done_s = (timer_r == TIMER_ZERO) ||
                     (ped_wait_r && (green_elapsed_r >= GREEN_MIN_M1));
`else
      green_done_s = (timer_r == TIMER_ZERO);
`endif
   end

   // Next-state, timer, phase and pedestrian-latch logic.
   always_comb begin
      state_nxt_s    = state_r;
      timer_nxt_s    = timer_r;
      phase_nxt_s    = phase_r;
      // Requests are latched in every state except WALK, where they are
      // deliberately dropped so one press never yields two walks.
      ped_wait_nxt_s = ped_wait_r | ((state_r != ST_WALK) & ped_request);

      case (state_r)
         ST_GREEN: begin
            if (green_done_s) begin
               state_nxt_s = ST_YELLOW;
               timer_nxt_s = YELLOW_LOAD;
            end else begin
               timer_nxt_s = timer_r - TIMER_ONE;
            end
         end
         ST_YELLOW: begin
            if (timer_r == TIMER_ZERO) begin
               state_nxt_s = ST_ALLRED;
               timer_nxt_s = ALLRED_LOAD;
            end else begin
               timer_nxt_s = timer_r - TIMER_ONE;
            end
         end
         ST_ALLRED: begin
            if (timer_r == TIMER_ZERO) begin
               // Decision uses the latched request only; a press arriving
               // in this very cycle is held over to the next clearance.
               if (ped_wait_r) begin
                  state_nxt_s    = ST_WALK;
                  timer_nxt_s    = WALK_LOAD;
                  ped_wait_nxt_s = 1'b0;
               end else begin
                  state_nxt_s = ST_GREEN;
                  timer_nxt_s = GREEN_LOAD;
                  phase_nxt_s = next_phase(phase_r);
               end
            end else begin
               timer_nxt_s = timer_r - TIMER_ONE;
            end
         end
         ST_WALK: begin
            if (timer_r == TIMER_ZERO) begin
               state_nxt_s = ST_GREEN;
               timer_nxt_s = GREEN_LOAD;
               phase_nxt_s = next_phase(phase_r);
            end else begin
               timer_nxt_s = timer_r - TIMER_ONE;
            end
         end
         default: begin
            state_nxt_s    = ST_GREEN;
            timer_nxt_s    = GREEN_LOAD;
            phase_nxt_s    = PH_ZERO;
            ped_wait_nxt_s = 1'b0;
         end
      endcase
   end

`ifdef PED_EARLY_CUT_EN
   // Green-elapsed count restarts whenever green is (re)entered.
   always_comb begin
      if ((state_r == ST_GREEN) && (state_nxt_s == ST_GREEN)) begin
         green_elapsed_nxt_s = green_elapsed_r + TIMER_ONE;
      end else begin
         green_elapsed_nxt_s = TIMER_ZERO;
      end
   end

   // Green-elapsed counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         green_elapsed_r <= TIMER_ZERO;
      end else begin
         green_elapsed_r <= green_elapsed_nxt_s;
      end
   end
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_GREEN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Timer, phase, request latch and registered outputs. The outputs are
   // computed from the next-state values so they line up with the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         timer_r     <= GREEN_LOAD;
         phase_r     <= PH_ZERO;
         ped_wait_r  <= 1'b0;
         light_r     <= encode_light(ST_GREEN, PH_ZERO);
         ped_light_r <= 1'b0;
      end else begin
         timer_r     <= timer_nxt_s;
         phase_r     <= phase_nxt_s;
         ped_wait_r  <= ped_wait_nxt_s;
         light_r     <= encode_light(state_nxt_s, phase_nxt_s);
         ped_light_r <= (state_nxt_s == ST_WALK);
      end
   end

   assign light     = light_r;
   assign ped_light = ped_light_r;
   assign ped_wait  = ped_wait_r;
   assign phase     = phase_r;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// ---------------------------------------------------------------------------
// Directed bench for traffic_phase_controller. A default 2-phase instance
// is exercised through the nominal cycle, pedestrian service, request
// filtering during WALK, mid-walk reset and a request landing on the
// all-red -> green edge. A second 3-phase instance with all times = 1
// checks one-cycle states and phase wrap. Expected green length follows
// PED_EARLY_CUT_EN so the bench works with either build.
// ---------------------------------------------------------------------------
module tb_traffic_phase_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ped_request = 1'b0;
   logic       ped_request3 = 1'b0;

   logic [3:0] light_s;
   logic       ped_light_s;
   logic       ped_wait_s;
   logic [0:0] phase_s;

   logic [5:0] light3_s;
   logic       ped_light3_s;
   logic       ped_wait3_s;
   logic [1:0] phase3_s;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef PED_EARLY_CUT_EN
   localparam int EXP_GREEN = 3;
`else
   localparam int EXP_GREEN = 8;
`endif

   // Hand-computed 2-phase light vectors (phase 1 in [3:2], phase 0 in [1:0]).
   localparam logic [3:0] L_G0 = 4'b0001;
   localparam logic [3:0] L_Y0 = 4'b0010;
   localparam logic [3:0] L_G1 = 4'b0100;
   localparam logic [3:0] L_Y1 = 4'b1000;
   localparam logic [3:0] L_RR = 4'b0000;

   // 3-phase, all times 1: G0 Y0 R G1 Y1 R G2 Y2 R G0.
   localparam logic [5:0] EXP3_LIGHT [10] = '{
      6'b000001, 6'b000010, 6'b000000,
      6'b000100, 6'b001000, 6'b000000,
      6'b010000, 6'b100000, 6'b000000,
      6'b000001 };
   localparam logic [1:0] EXP3_PHASE [10] = '{
      2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0 };

   traffic_phase_controller u_dut (
      .clk         (clk),
      .reset       (reset),
      .ped_request (ped_request),
      .light       (light_s),
      .ped_light   (ped_light_s),
      .ped_wait    (ped_wait_s),
      .phase       (phase_s)
   );

   traffic_phase_controller #(
      .NUM_PHASES  (3),
      .GREEN_TIME  (1),
      .GREEN_MIN   (1),
      .YELLOW_TIME (1),
      .ALLRED_TIME (1),
      .WALK_TIME   (1)
   ) u_dut3 (
      .clk         (clk),
      .reset       (reset),
      .ped_request (ped_request3),
      .light       (light3_s),
      .ped_light   (ped_light3_s),
      .ped_wait    (ped_wait3_s),
      .phase       (phase3_s)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Check n consecutive cycles of the 2-phase DUT, advancing one cycle each.
   task automatic expect_run(input string tag, input int n,
                             input logic [3:0] exp_light, input logic exp_pl,
                             input logic exp_pw, input logic exp_ph);
      for (int i = 0; i < n; i++) begin
         check_eq({tag, "_light"}, 32'(light_s), 32'(exp_light));
         check_eq({tag, "_pedl"},  32'(ped_light_s), 32'(exp_pl));
         check_eq({tag, "_pedw"},  32'(ped_wait_s), 32'(exp_pw));
         check_eq({tag, "_phase"}, 32'(phase_s), 32'(exp_ph));
         @(negedge clk);
      end
   endtask

   // Reset for one posedge; returns at the negedge of the first cycle.
   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic int count_11(input logic [5:0] v);
      int c;
      c = 0;
      for (int p = 0; p < 3; p++) begin
         if (v[2*p +: 2] == 2'b11) c++;
      end
      return c;
   endfunction

   initial begin
      // --- Reset state and nominal 22-cycle period, no requests ---
      do_reset();
      check_eq("rst_light", 32'(light_s), 32'(L_G0));
      check_eq("rst_pedl",  32'(ped_light_s), 32'd0);
      check_eq("rst_pedw",  32'(ped_wait_s), 32'd0);
      check_eq("rst_phase", 32'(phase_s), 32'd0);
      expect_run("nom_g0", 8, L_G0, 1'b0, 1'b0, 1'b0);
      expect_run("nom_y0", 2, L_Y0, 1'b0, 1'b0, 1'b0);
      expect_run("nom_r0", 1, L_RR, 1'b0, 1'b0, 1'b0);
      expect_run("nom_g1", 8, L_G1, 1'b0, 1'b0, 1'b1);
      expect_run("nom_y1", 2, L_Y1, 1'b0, 1'b0, 1'b1);
      expect_run("nom_r1", 1, L_RR, 1'b0, 1'b0, 1'b1);
      expect_run("nom_wrap", 1, L_G0, 1'b0, 1'b0, 1'b0);

      // --- Pulse in green cycle 1, then request held through WALK ---
      do_reset();
      ped_request = 1'b1;
      @(negedge clk);
      ped_request = 1'b0;
      check_eq("ped_set", 32'(ped_wait_s), 32'd1);
      expect_run("ped_g0", EXP_GREEN - 1, L_G0, 1'b0, 1'b1, 1'b0);
      expect_run("ped_y0", 2, L_Y0, 1'b0, 1'b1, 1'b0);
      expect_run("ped_r0", 1, L_RR, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         ped_request = 1'b1;
         check_eq("walk_light", 32'(light_s), 32'(L_RR));
         check_eq("walk_pedl",  32'(ped_light_s), 32'd1);
         check_eq("walk_pedw",  32'(ped_wait_s), 32'd0);
         check_eq("walk_phase", 32'(phase_s), 32'd0);
         @(negedge clk);
      end
      ped_request = 1'b0;
      expect_run("post_g1", 8, L_G1, 1'b0, 1'b0, 1'b1);
      expect_run("post_y1", 2, L_Y1, 1'b0, 1'b0, 1'b1);
      expect_run("post_r1", 1, L_RR, 1'b0, 1'b0, 1'b1);
      expect_run("post_g0", 1, L_G0, 1'b0, 1'b0, 1'b0);

      // --- Reset (with simultaneous request) in WALK cycle 2 ---
      do_reset();
      ped_request = 1'b1;
      @(negedge clk);
      ped_request = 1'b0;
      repeat (EXP_GREEN + 3) @(negedge clk);
      check_eq("w2_pedl", 32'(ped_light_s), 32'd1);
      reset = 1'b1;
      ped_request = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      ped_request = 1'b0;
      expect_run("wrst_g0", 8, L_G0, 1'b0, 1'b0, 1'b0);
      expect_run("wrst_y0", 1, L_Y0, 1'b0, 1'b0, 1'b0);

      // --- Request coinciding with ALLRED -> GREEN ---
      do_reset();
      repeat (10) @(negedge clk);
      check_eq("edge_ar", 32'(light_s), 32'(L_RR));
      ped_request = 1'b1;
      @(negedge clk);
      ped_request = 1'b0;
      expect_run("edge_g1", EXP_GREEN, L_G1, 1'b0, 1'b1, 1'b1);
      expect_run("edge_y1", 2, L_Y1, 1'b0, 1'b1, 1'b1);
      expect_run("edge_r1", 1, L_RR, 1'b0, 1'b1, 1'b1);
      expect_run("edge_wk", 4, L_RR, 1'b1, 1'b0, 1'b1);
      expect_run("edge_g0", 1, L_G0, 1'b0, 1'b0, 1'b0);

      // --- 3 phases, all times 1 ---
      do_reset();
      for (int i = 0; i < 10; i++) begin
         check_eq("p3_light", 32'(light3_s), 32'(EXP3_LIGHT[i]));
         check_eq("p3_phase", 32'(phase3_s), 32'(EXP3_PHASE[i]));
         check_eq("p3_no11",  32'(count_11(light3_s)), 32'd0);
         check_eq("p3_pedl",  32'(ped_light3_s), 32'd0);
         check_eq("p3_pedw",  32'(ped_wait3_s), 32'd0);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
